// File: rtl/aes_io_pkg.sv
// Shared constants and state encoding for the AES byte-serial I/O stages.
package aes_io_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/aes_byte_serializer.sv
// Block shift register with byte down-counter; presents the top byte as dout.
module aes_byte_serializer
  import aes_io_pkg::*;
#(
  parameter int unsigned NBYTES = AES_BLOCK_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     active_i,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic [NBYTES*BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0]        dout_o,
  output logic                     dout_valid_o,
  output logic                     dout_last_o
);

  localparam int unsigned W     = NBYTES * BYTE_W;
  localparam int unsigned CNT_W = $clog2(NBYTES);

  logic [W-1:0]     sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // A load wins over a shift: the final transfer of a block may reload in the same cycle.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = CNT_W'(NBYTES - 1);
    end else if (shift_i) begin
      sreg_d = {sreg_q[W-BYTE_W-1:0], BYTE_W'(0)};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  assign dout_o       = sreg_q[W-1 -: BYTE_W];
  assign dout_valid_o = active_i;
  assign dout_last_o  = active_i && (cnt_q == '0);

endmodule

// File: rtl/output_interface.sv
// Byte-serial ciphertext output stage, MSB first, with sticky overflow flag.
// OUTPUT_INTERFACE_BUFFER_EN adds a one-block holding register behind the shift register.
module output_interface
  import aes_io_pkg::*;
#(
  parameter int unsigned NBYTES = AES_BLOCK_BYTES
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [NBYTES*8-1:0] cipher_in,
  input  logic                engine_done,
  output logic [7:0]          dout,
  output logic                dout_valid,
  input  logic                dout_ack,
  output logic                dout_last,
  output logic                busy,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int unsigned W = NBYTES * BYTE_W;

  state_e       state_q, state_d;
  logic         overflow_q, overflow_d;
  logic         xfer_c, last_xfer_c;
  logic         load_c, load_buf_c, shift_c, drop_c;
  logic [W-1:0] load_data_c;
  logic         buf_full;
  logic [W-1:0] buf_data;
  logic         buf_push_c;

  assign xfer_c      = (state_q == S_SEND) && dout_ack;
  assign last_xfer_c = xfer_c && dout_last;

`ifdef OUTPUT_INTERFACE_BUFFER_EN
  logic         buf_full_q, buf_full_d;
  logic [W-1:0] buf_data_q, buf_data_d;

  // Capture when empty and the shift register stays busy, or when full and draining into it.
  assign buf_push_c = engine_done && (state_q == S_SEND) && (buf_full_q == last_xfer_c);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (buf_push_c) begin
      buf_full_d = 1'b1;
      buf_data_d = cipher_in;
    end else if (last_xfer_c && buf_full_q) begin
      buf_full_d = 1'b0;
    end
  end

  assign buf_full = buf_full_q;
  assign buf_data = buf_data_q;
`else
  assign buf_full   = 1'b0;
  assign buf_data   = '0;
  assign buf_push_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    load_c     = 1'b0;
    load_buf_c = 1'b0;
    shift_c    = 1'b0;
    drop_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (engine_done) begin
          load_c  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        shift_c = xfer_c;
        if (last_xfer_c) begin
          if (buf_full) begin
            load_c     = 1'b1;
            load_buf_c = 1'b1;
          end else if (engine_done) begin
            load_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        // A result neither loaded directly nor buffered is lost.
        if (engine_done && !(last_xfer_c && !buf_full) && !buf_push_c) begin
          drop_c = 1'b1;
        end
      end
    endcase
    if (ovf_clr) overflow_d = 1'b0;
    if (drop_c)  overflow_d = 1'b1;
  end

  assign load_data_c = load_buf_c ? buf_data : cipher_in;

  aes_byte_serializer #(
    .NBYTES (NBYTES)
  ) u_ser (
    .clk          (clk),
    .rst_         (rst_),
    .active_i     (state_q == S_SEND),
    .load_i       (load_c),
    .shift_i      (shift_c),
    .data_i       (load_data_c),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_last_o  (dout_last)
  );

  assign busy     = (state_q == S_SEND) || buf_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface: vector table plus multi-cycle corner sequences.
module tb_output_interface;

  logic         clk;
  logic         rst_;
  logic [127:0] cipher_in;
  logic         engine_done;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_ack;
  logic         dout_last;
  logic         busy;
  logic         overflow;
  logic         ovf_clr;

  int n_checks;
  int n_fail;

  typedef struct {
    logic         ed;
    logic         ack;
    logic [127:0] cin;
    logic         v;
    logic [7:0]   d;
    logic         last;
    logic         bsy;
  } vec_t;

  vec_t tbl[$];

  logic [127:0] blk_a;
  logic [127:0] blk_b;
  logic [127:0] blk_c;
  logic [7:0]   a_b[16];
  logic [7:0]   b_b[16];
  logic         exp_ovf;

`ifdef OUTPUT_INTERFACE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  output_interface #(.NBYTES(16)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .cipher_in   (cipher_in),
    .engine_done (engine_done),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ack    (dout_ack),
    .dout_last   (dout_last),
    .busy        (busy),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic ed, input logic ack, input logic clr, input logic [127:0] cin);
    engine_done = ed;
    dout_ack    = ack;
    ovf_clr     = clr;
    cipher_in   = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ed, input logic ack, input logic [127:0] cin,
                      input logic v, input logic [7:0] d, input logic last, input logic bsy);
    vec_t r;
    r.ed = ed; r.ack = ack; r.cin = cin; r.v = v; r.d = d; r.last = last; r.bsy = bsy;
    tbl.push_back(r);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    blk_a = 128'h3925841D02DC09FBDC118597196A0B32;
    blk_b = 128'h00112233445566778899AABBCCDDEEFF;
    blk_c = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    for (int i = 0; i < 16; i++) begin
      a_b[i] = blk_a[127-8*i -: 8];
      b_b[i] = blk_b[127-8*i -: 8];
    end

    // Single block with 1,0,0,1 backpressure, idle ack, then coincident back-to-back.
    push(1, 0, blk_a, 1, a_b[0], 0, 1);
    push(0, 1, blk_a, 1, a_b[1], 0, 1);
    push(0, 0, blk_a, 1, a_b[1], 0, 1);
    push(0, 0, blk_a, 1, a_b[1], 0, 1);
    push(0, 1, blk_a, 1, a_b[2], 0, 1);
    for (int i = 3; i < 16; i++) push(0, 1, blk_a, 1, a_b[i], 1'(i == 15), 1);
    push(0, 1, blk_a, 0, 8'h00, 0, 0);
    push(0, 1, blk_a, 0, 8'h00, 0, 0);
    push(1, 0, blk_a, 1, a_b[0], 0, 1);
    for (int i = 1; i < 16; i++) push(0, 1, blk_a, 1, a_b[i], 1'(i == 15), 1);
    push(1, 1, blk_b, 1, b_b[0], 0, 1);
    for (int i = 1; i < 16; i++) push(0, 1, blk_b, 1, b_b[i], 1'(i == 15), 1);
    push(0, 1, blk_b, 0, 8'h00, 0, 0);

    rst_ = 1'b0; engine_done = 1'b0; dout_ack = 1'b0; ovf_clr = 1'b0; cipher_in = '0;
    #12;
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset valid", 32'(dout_valid), 32'h0);
    chk("reset last", 32'(dout_last), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].ed, tbl[i].ack, 1'b0, tbl[i].cin);
      chk($sformatf("row%0d valid", i), 32'(dout_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d last", i), 32'(dout_last), 32'(tbl[i].last));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'h0);
      if (tbl[i].v) chk($sformatf("row%0d dout", i), 32'(dout), 32'(tbl[i].d));
    end

    // Mid-stream second result (buffered or dropped), third result while buffer is full.
    cyc(1, 1, 0, blk_a);
    chk("ovf dout0", 32'(dout), 32'(a_b[0]));
    cyc(0, 1, 0, blk_a);
    chk("ovf dout1", 32'(dout), 32'(a_b[1]));
    cyc(1, 1, 0, blk_b);
    chk("ovf dout2", 32'(dout), 32'(a_b[2]));
    exp_ovf = !BUF;
    chk("ovf after second", 32'(overflow), 32'(exp_ovf));
    for (int i = 3; i < 16; i++) begin
      cyc(1'(i == 5), 1, 0, blk_c);
      if (i >= 5) exp_ovf = 1'b1;
      chk($sformatf("ovf stream byte%0d", i), 32'(dout), 32'(a_b[i]));
      chk($sformatf("ovf flag byte%0d", i), 32'(overflow), 32'(exp_ovf));
      chk($sformatf("ovf busy byte%0d", i), 32'(busy), 32'h1);
    end
    chk("ovf last byte", 32'(dout_last), 32'h1);
    cyc(0, 1, 0, blk_c);
`ifdef OUTPUT_INTERFACE_BUFFER_EN
    chk("buf next valid", 32'(dout_valid), 32'h1);
    chk("buf next dout", 32'(dout), 32'(b_b[0]));
    for (int i = 1; i < 16; i++) begin
      cyc(0, 1, 0, blk_c);
      chk($sformatf("buf byte%0d", i), 32'(dout), 32'(b_b[i]));
    end
    chk("buf last", 32'(dout_last), 32'h1);
    cyc(0, 1, 0, blk_c);
`endif
    chk("drain valid", 32'(dout_valid), 32'h0);
    chk("drain busy", 32'(busy), 32'h0);
    chk("ovf sticky", 32'(overflow), 32'h1);
    cyc(0, 0, 1, blk_c);
    chk("ovf cleared", 32'(overflow), 32'h0);
    cyc(0, 0, 0, blk_c);
    chk("ovf stays clear", 32'(overflow), 32'h0);

    // Set wins over a simultaneous clear; stalled stream is untouched.
    cyc(1, 0, 0, blk_a);
    chk("prio dout0", 32'(dout), 32'(a_b[0]));
    cyc(1, 0, 1, blk_b);
    chk("prio first", 32'(overflow), 32'(!BUF));
    cyc(1, 0, 1, blk_c);
    chk("prio second", 32'(overflow), 32'h1);
    chk("prio hold dout", 32'(dout), 32'(a_b[0]));
    chk("prio hold last", 32'(dout_last), 32'h0);

    // Reset after the 5th byte is consumed.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, blk_a);
    chk("pre-reset dout", 32'(dout), 32'(a_b[5]));
    dout_ack = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    chk("mid reset valid", 32'(dout_valid), 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    chk("mid reset dout", 32'(dout), 32'h0);
    chk("mid reset overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    cyc(0, 1, 0, blk_a);
    chk("post reset idle", 32'(dout_valid), 32'h0);
    cyc(1, 1, 0, blk_a);
    chk("restart dout", 32'(dout), 32'(a_b[0]));
    chk("restart valid", 32'(dout_valid), 32'h1);
    cyc(0, 1, 0, blk_a);
    chk("restart dout1", 32'(dout), 32'(a_b[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
